// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operations and datapath mux selects.
package ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t FETCH    = 4'd0;
  localparam state_t DECODE   = 4'd1;
  localparam state_t MEMADR   = 4'd2;
  localparam state_t MEMRD    = 4'd3;
  localparam state_t MEMWB    = 4'd4;
  localparam state_t MEMWR    = 4'd5;
  localparam state_t EXECUTER = 4'd6;
  localparam state_t EXECUTEI = 4'd7;
  localparam state_t ALUWB    = 4'd8;
  localparam state_t BRANCH   = 4'd9;
  localparam state_t UNKNOWN  = 4'd10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [7:0] WAIT_LIMIT = 8'd254;

  // States that wait on the memory handshake
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/ctrl_alu_decoder.sv
// Data-processing decode: ALU operation and flag-write requests from Funct[4:0].
module ctrl_alu_decoder
  import ctrl_pkg::*;
(
  input  logic [4:0] funct,
  input  logic       en,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  // Unrecognised commands fall back to ADD and never update flags
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (en) begin
      case (funct[4:1])
        4'b0100: begin
          alu_control = ALU_ADD;
          flag_w      = {funct[0], funct[0]};
        end
        4'b0010: begin
          alu_control = ALU_SUB;
          flag_w      = {funct[0], funct[0]};
        end
        4'b0000: begin
          alu_control = ALU_AND;
          flag_w      = {funct[0], 1'b0};
        end
        4'b1100: begin
          alu_control = ALU_ORR;
          flag_w      = {funct[0], 1'b0};
        end
        default: begin
          alu_control = ALU_ADD;
          flag_w      = 2'b00;
        end
      endcase
    end else begin
      alu_control = ALU_ADD;
      flag_w      = 2'b00;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM. Define CTRL_MEMWAIT_EN to add the
// MemReady handshake with an 8-bit stall counter and timeout.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
`ifdef CTRL_MEMWAIT_EN
  input  logic       MemReady,
`endif
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       PCS,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic [1:0] ImmSrc
);

  state_t state;
  state_t state_next;
  state_t dec_state;
  logic   alu_en;
  logic   fetch_ok;

`ifdef CTRL_MEMWAIT_EN
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       stall;
  logic       timeout;

  assign stall    = is_mem_state(state) && !MemReady;
  assign timeout  = stall && (wait_cnt == WAIT_LIMIT);
  assign fetch_ok = MemReady;

  // Stall counter: counts held cycles, clears whenever the state moves on
  always_comb begin
    if (stall && !timeout) begin
      wait_next = wait_cnt + 8'd1;
    end else begin
      wait_next = 8'd0;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_next;
    end
  end
`else
  assign fetch_ok = 1'b1;
`endif

  // Next-state selection
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_next = BRANCH;
          default: state_next = UNKNOWN;
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
`ifdef CTRL_MEMWAIT_EN
    if (timeout) begin
      state_next = FETCH;
    end else if (stall) begin
      state_next = state;
    end else begin
      state_next = state_next;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  assign dec_state = reset ? FETCH : state;
  assign alu_en    = (dec_state == EXECUTER) || (dec_state == EXECUTEI);

  ctrl_alu_decoder u_alu_decoder (
    .funct       (Funct[4:0]),
    .en          (alu_en),
    .alu_control (ALUControl),
    .flag_w      (FlagW)
  );

  // Moore output decode; reset holds the FETCH pattern without its writes
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    case (dec_state)
      FETCH: begin
        IRWrite   = fetch_ok && !reset;
        NextPC    = fetch_ok && !reset;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUSrcB = SRCB_REG;
      EXECUTEI: ALUSrcB = SRCB_IMM;
      ALUWB:    RegW    = 1'b1;
      BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
      end
      default: begin
        IRWrite = 1'b0;
        NextPC  = 1'b0;
      end
    endcase
  end

  assign PCS    = (RegW && (Rd == 4'b1111)) || Branch;
  assign ImmSrc = Op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; covers the
// CTRL_MEMWAIT_EN handshake when that macro is defined.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       mem_ready;
  logic       IRWrite, NextPC, RegW, MemW, Branch, PCS, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
`ifdef CTRL_MEMWAIT_EN
    .MemReady   (mem_ready),
`endif
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .PCS        (PCS),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .ImmSrc     (ImmSrc)
  );

  // {IRWrite,NextPC,RegW,MemW,Branch,PCS,AdrSrc,SrcA,SrcB,Result,ALU,FlagW,Imm}
  wire [18:0] outs = {IRWrite, NextPC, RegW, MemW, Branch, PCS, AdrSrc,
                      ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc};

  function automatic logic [18:0] mk(input logic [6:0] strobes, input logic [1:0] asa,
                                     input logic [1:0] asb, input logic [1:0] rs,
                                     input logic [1:0] aluc, input logic [1:0] fw,
                                     input logic [1:0] imm);
    return {strobes, asa, asb, rs, aluc, fw, imm};
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    Op = op; Funct = f; Rd = rd;
    #1;
    check_value("fetch", outs, mk(7'b1100000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, op));
    step();
    check_value("decode", outs, mk(7'b0000000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, op));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'b000000; Rd = 4'b0000; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_value("reset_outs", outs, mk(7'b0000000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    reset = 1'b0;

    // ADD r3
    start_instr(2'b00, 6'b001000, 4'b0011);
    step(); check_value("add_exec", outs, mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    step(); check_value("add_wb", outs, mk(7'b0010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    step();
    // SUBS immediate
    start_instr(2'b00, 6'b100101, 4'b0001);
    step(); check_value("subs_exec", outs, mk(7'b0000000, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00));
    step(); check_value("subs_wb", outs, mk(7'b0010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    step();
    // ORR to r15 -> PCS
    start_instr(2'b00, 6'b011000, 4'b1111);
    step(); check_value("orr_exec", outs, mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    step(); check_value("orr_wb_pcs", outs, mk(7'b0010010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    step();
    // ANDS: N/Z only
    start_instr(2'b00, 6'b000001, 4'b0100);
    step(); check_value("ands_exec", outs, mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00));
    step(); step();
    // unsupported command with S set: ADD, no flags
    start_instr(2'b00, 6'b010111, 4'b0100);
    step(); check_value("badcmd_exec", outs, mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    step(); step();
    // LDR r15
    start_instr(2'b01, 6'b011001, 4'b1111);
    step(); check_value("ldr_adr", outs, mk(7'b0000000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    step(); check_value("ldr_rd", outs, mk(7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    step(); check_value("ldr_wb", outs, mk(7'b0010010, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01));
    step();
    // STR
    start_instr(2'b01, 6'b011000, 4'b0010);
    step(); check_value("str_adr", outs, mk(7'b0000000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    step(); check_value("str_wr", outs, mk(7'b0001001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    step();
    // B
    start_instr(2'b10, 6'b000000, 4'b0000);
    step(); check_value("b_branch", outs, mk(7'b0000110, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10));
    step();
    // undefined opcode
    start_instr(2'b11, 6'b111111, 4'b1111);
    step(); check_value("undef", outs, mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11));
    step();
    // reset during MEMRD
    start_instr(2'b01, 6'b011001, 4'b1111);
    step(); step();
    check_value("rst_pre_rd", outs, mk(7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    reset = 1'b1;
    #1;
    check_value("rst_in_rd", outs, mk(7'b0000000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01));
    step();
    check_value("rst_held", outs, mk(7'b0000000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01));
    reset = 1'b0;
    start_instr(2'b01, 6'b011001, 4'b0001);
    step(); step(); step(); step();

`ifdef CTRL_MEMWAIT_EN
    // STR with three not-ready cycles
    start_instr(2'b01, 6'b011000, 4'b0010);
    step(); step();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_value("wr_wait", outs, mk(7'b0001001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
      step();
    end
    mem_ready = 1'b1;
    #1;
    check_value("wr_done", outs, mk(7'b0001001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    step();
    // LDR with memory stuck: abandon after 255 stalled cycles
    start_instr(2'b01, 6'b011001, 4'b0011);
    step(); step();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 255; i++) begin
      check_value("rd_stuck", outs, mk(7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
      step();
    end
    check_value("rd_abandon", outs, mk(7'b0000000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01));
    mem_ready = 1'b1;
    #1;
    check_value("fetch_ready", outs, mk(7'b1100000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from ctrl_pkg.
REQ-002 The block SHALL have these ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 Op  in  2  instr[27:26]; Funct  in  6  instr[25:20]; Rd  in  4  instr[15:12].
REQ-005 MemReady  in  1  memory access complete; present only with CTRL_MEMWAIT_EN.
REQ-006 IRWrite, NextPC, RegW, MemW, Branch, PCS, AdrSrc  out  1 each; ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc  out  2 each.
REQ-007 RegW, MemW, Branch, PCS and FlagW SHALL be unqualified requests, gated by the downstream condition-check logic; NextPC SHALL be an unconditional PC write.

Function
REQ-008 The FSM SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH and UNKNOWN.
REQ-009 FETCH SHALL go to DECODE.
REQ-010 DECODE SHALL go to MEMADR when Op=01, to EXECUTER when Op=00 and Funct[5]=0, to EXECUTEI when Op=00 and Funct[5]=1, to BRANCH when Op=10, and to UNKNOWN when Op=11.
REQ-011 MEMADR SHALL go to MEMRD when Funct[0]=1 and to MEMWR when Funct[0]=0; MEMRD SHALL go to MEMWB.
REQ-012 EXECUTER and EXECUTEI SHALL go to ALUWB; MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN SHALL go to FETCH.
REQ-013 Every output SHALL be a combinational function of state and inputs (Moore except ALU decode); every output not listed for a state SHALL be 0.
REQ-014 FETCH SHALL drive IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10 and ALUControl=00.
REQ-015 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10 and ResultSrc=10.
REQ-016 MEMADR SHALL drive ALUSrcA=00 and ALUSrcB=01.
REQ-017 MEMRD SHALL drive AdrSrc=1; MEMWB SHALL drive ResultSrc=01 and RegW=1; MEMWR SHALL drive AdrSrc=1 and MemW=1.
REQ-018 EXECUTER SHALL drive ALUSrcA=00, ALUSrcB=00 and ALU decode; EXECUTEI SHALL drive ALUSrcA=00, ALUSrcB=01 and ALU decode; ALUWB SHALL drive ResultSrc=00 and RegW=1.
REQ-019 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=01, ResultSrc=10 and Branch=1; UNKNOWN SHALL drive all outputs 0, so no architectural write occurs.
REQ-020 ALU decode SHALL set ALUControl from Funct[4:1]: 0100 gives 00 (ADD), 0010 gives 01 (SUB), 0000 gives 10 (AND), 1100 gives 11 (ORR); any other value SHALL give 00 with FlagW=00.
REQ-021 During ALU decode, FlagW[1] SHALL equal Funct[0], and FlagW[0] SHALL equal Funct[0] AND (ADD or SUB); outside EXECUTER/EXECUTEI, FlagW SHALL be 00.
REQ-022 PCS SHALL equal (RegW AND Rd=1111) OR Branch.
REQ-023 ImmSrc SHALL equal Op in all states.
REQ-024 Latency SHALL be: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 3 (zero-wait memory).

Reset
REQ-025 When reset=1 at a clock edge, the state SHALL become FETCH (wait counter 0), overriding any transition, including mid-instruction.
REQ-026 While reset is high, outputs SHALL follow FETCH decode, except that IRWrite and NextPC SHALL be forced to 0.

Configuration
REQ-027 The macro CTRL_MEMWAIT_EN SHALL control memory wait states.
REQ-028 With CTRL_MEMWAIT_EN defined, the port MemReady SHALL exist, and FETCH, MEMRD and MEMWR SHALL hold their state while MemReady=0.
REQ-029 With CTRL_MEMWAIT_EN defined, IRWrite and NextPC in FETCH SHALL assert only in the cycle where MemReady=1.
REQ-030 With CTRL_MEMWAIT_EN defined, MemW SHALL stay high through the MEMWR wait and the state SHALL advance on MemReady=1.
REQ-031 With CTRL_MEMWAIT_EN defined, an 8-bit wait counter SHALL count stalled cycles and clear when the state advances; on reaching 255 the FSM SHALL abandon to FETCH with no RegW/MemW pulse.
REQ-032 Without CTRL_MEMWAIT_EN, the MemReady port and the counter SHALL be absent and timing SHALL be exactly as in REQ-024.

Structure
REQ-033 ctrl_pkg SHALL hold the state enum (4-bit), the Op codes (DP=00, MEM=01, BR=10), the ALUControl codes and the ALUSrc/ResultSrc encodings.
REQ-034 ALU decode and FlagW SHALL live in sub-module ctrl_alu_decoder (combinational, Funct plus enable in, ALUControl/FlagW out); the FSM and counter SHALL remain in multicycle_controller.

Verification
REQ-035 ADD (Op=00, Funct=001000, Rd=0011) -> FETCH, DECODE, EXECUTER (ALUControl=00, FlagW=00), ALUWB (RegW=1, PCS=0), FETCH.
REQ-036 SUBS immediate (Funct=100101) -> EXECUTEI with ALUSrcB=01, ALUControl=01, FlagW=11.
REQ-037 LDR (Op=01, Funct=011001) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1); with Rd=1111, PCS=1 in MEMWB.
REQ-038 B (Op=10) -> BRANCH (Branch=1, PCS=1, ALUSrcA=10), FETCH at cycle 3; Op=11 -> UNKNOWN with all write enables 0.
REQ-039 CTRL_MEMWAIT_EN with STR and MemReady low for 3 cycles -> MEMWR held 4 cycles with MemW=1, then FETCH; MemReady stuck at 0 -> FETCH after 255 stall cycles with no write.
REQ-040 reset asserted during MEMRD -> next cycle FETCH, with IRWrite=0 while reset=1 and no RegW pulse.
